// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl: VGA raster timing, linear pixel fetch and a
// frame-boundary swapped frame-buffer pointer.
// Optional build macro: VGA_TEST_PATTERN_EN (adds test_mode, colour bars).
// Ports: clk, reset_n | fb_ptr_in/wr -> fb_ptr_active, swap_pending,
// frame_done | pix_req/pix_addr out, pix_data in | vga_* DAC pins.
module vga_scan_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0,
  parameter int PIX_LAT = 2,
  parameter int ADDR_W = 32,
  parameter int BYTES_PP = 4,
  parameter logic [ADDR_W-1:0] FB_RESET_PTR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  input  logic [ADDR_W-1:0] fb_ptr_in,
  input  logic              fb_ptr_wr,
  output logic [ADDR_W-1:0] fb_ptr_active,
  output logic              swap_pending,
  output logic              frame_done,
  output logic              pix_req,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_data,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank_n,
  output logic              vga_sync_n
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  localparam int unsigned HS_BEG = H_ACTIVE + H_FP;
  localparam int unsigned HS_END = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG = V_ACTIVE + V_FP;
  localparam int unsigned VS_END = VS_BEG + V_SYNC;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank_n;
`ifdef VGA_TEST_PATTERN_EN
    logic        tm;
    logic [23:0] bars;
`endif
  } vid_t;

  logic [HW-1:0]     h;
  logic [VW-1:0]     v;
  int unsigned       hi;
  int unsigned       vi;
  logic              h_last;
  logic              v_last;
  logic              active;
  logic              frame_start;
  logic [ADDR_W-1:0] pend;
  logic [ADDR_W-1:0] addr_q;
  logic [23:0]       rgb_q;
  vid_t              cur;
  vid_t              vid_rst;
  vid_t              tap;
  vid_t              pipe [PIX_LAT+1];

  assign hi = 32'(h);
  assign vi = 32'(v);
  assign h_last = (hi == H_TOT - 1);
  assign v_last = (vi == V_TOT - 1);
  assign active = (hi < H_ACTIVE) && (vi < V_ACTIVE);
  assign frame_start = (h == '0) && (v == '0);
  assign frame_done = h_last && v_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h <= '0;
      v <= '0;
    end else if (h_last) begin
      h <= '0;
      v <= v_last ? '0 : v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  // Boundary write bypasses the pending slot and wins over it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_ptr_active <= FB_RESET_PTR;
      pend <= FB_RESET_PTR;
      swap_pending <= 1'b0;
    end else if (frame_done && fb_ptr_wr) begin
      fb_ptr_active <= fb_ptr_in;
      swap_pending <= 1'b0;
    end else if (frame_done && swap_pending) begin
      fb_ptr_active <= pend;
      swap_pending <= 1'b0;
    end else if (fb_ptr_wr) begin
      pend <= fb_ptr_in;
      swap_pending <= 1'b1;
    end
  end

  // Request is combinational with the count; gating by reset_n
  // keeps it low while held in reset at h=v=0.
`ifdef VGA_TEST_PATTERN_EN
  assign pix_req = reset_n && active && !test_mode;
`else
  assign pix_req = reset_n && active;
`endif

  assign pix_addr = frame_start ? fb_ptr_active : addr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= FB_RESET_PTR;
    end else if (pix_req) begin
      addr_q <= pix_addr + ADDR_W'(BYTES_PP);
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar;
  assign bar = 3'(hi * 8 / H_ACTIVE);
`endif

  always_comb begin
    cur = '0;
    cur.hs = ((hi >= HS_BEG) && (hi < HS_END)) ? HS_POL : ~HS_POL;
    cur.vs = ((vi >= VS_BEG) && (vi < VS_END)) ? VS_POL : ~VS_POL;
    cur.blank_n = active;
`ifdef VGA_TEST_PATTERN_EN
    cur.tm = test_mode;
    cur.bars = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
`endif
  end

  always_comb begin
    vid_rst = '0;
    vid_rst.hs = ~HS_POL;
    vid_rst.vs = ~VS_POL;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= PIX_LAT; i++) pipe[i] <= vid_rst;
    end else begin
      pipe[0] <= cur;
      for (int i = 1; i <= PIX_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // pix_data for a request lands while its stage sits at PIX_LAT-1,
  // so the rgb register lines up with the last delay stage.
  assign tap = pipe[PIX_LAT-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q <= '0;
    end else if (!tap.blank_n) begin
      rgb_q <= '0;
`ifdef VGA_TEST_PATTERN_EN
    end else if (tap.tm) begin
      rgb_q <= tap.bars;
`endif
    end else begin
      rgb_q <= pix_data;
    end
  end

  assign vga_r = rgb_q[23:16];
  assign vga_g = rgb_q[15:8];
  assign vga_b = rgb_q[7:0];
  assign vga_hs = pipe[PIX_LAT].hs;
  assign vga_vs = pipe[PIX_LAT].vs;
  assign vga_blank_n = pipe[PIX_LAT].blank_n;
  assign vga_sync_n = 1'b1;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb_vga_scan_ctrl: directed bench for vga_scan_ctrl on a
// 14x7 raster (H 8/2/2/2, V 4/1/1/1), PIX_LAT 2, 4 bytes/pixel.
module tb_vga_scan_ctrl;

  localparam int HT = 14;
  localparam int FT = 98;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] fb_ptr_in = '0;
  logic        fb_ptr_wr = 1'b0;
  logic [31:0] fb_ptr_active;
  logic        swap_pending;
  logic        frame_done;
  logic        pix_req;
  logic [31:0] pix_addr;
  logic [23:0] pix_data = '0;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_blank_n;
  logic        vga_sync_n;
`ifdef VGA_TEST_PATTERN_EN
  logic        test_mode = 1'b0;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] hist0 = '0;
  logic [31:0] hist1 = '0;

  vga_scan_ctrl #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(2),
    .ADDR_W(32), .BYTES_PP(4), .FB_RESET_PTR(32'h0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
`ifdef VGA_TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .fb_ptr_in(fb_ptr_in),
    .fb_ptr_wr(fb_ptr_wr),
    .fb_ptr_active(fb_ptr_active),
    .swap_pending(swap_pending),
    .frame_done(frame_done),
    .pix_req(pix_req),
    .pix_addr(pix_addr),
    .pix_data(pix_data),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .vga_hs(vga_hs),
    .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle's sampling point and return the
  // address requested two cycles earlier as pix_data.
  task automatic tick();
    @(negedge clk);
    fb_ptr_wr = 1'b0;
    pix_data = hist1[23:0];
    hist1 = hist0;
    hist0 = pix_addr;
  endtask

  task automatic release_rst();
    @(negedge clk);
    reset_n = 1'b1;
    pix_data = '0;
    hist1 = '0;
    #1;
    hist0 = pix_addr;
  endtask

  function automatic logic [31:0] base_of(input int c);
    int f;
    f = c / FT;
    if (f == 0) return 32'h0;
    if (f == 1) return 32'h1000;
    return 32'h2000;
  endfunction

  function automatic bit act_of(input int c);
    int r;
    r = c % FT;
    return ((r % HT) < 8) && ((r / HT) < 4);
  endfunction

  function automatic logic [31:0] addr_of(input int c);
    int r;
    r = c % FT;
    return base_of(c) + 32'(4 * ((r / HT) * 8 + (r % HT)));
  endfunction

  task automatic check_reset_vals();
    check("rst_req", pix_req, 0);
    check("rst_addr", pix_addr, 0);
    check("rst_active", fb_ptr_active, 0);
    check("rst_pending", swap_pending, 0);
    check("rst_done", frame_done, 0);
    check("rst_hs", vga_hs, 1);
    check("rst_vs", vga_vs, 1);
    check("rst_blank", vga_blank_n, 0);
    check("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    check("rst_sync", vga_sync_n, 1);
  endtask

  task automatic check_cycle(input int c);
    int d;
    int r;
    int hd;
    int vd;
    bit bl;
    logic [31:0] act;
    logic [31:0] rgb;
    check("pix_req", pix_req, 32'(act_of(c)));
    if (act_of(c)) check("pix_addr", pix_addr, addr_of(c));
    check("frame_done", frame_done, 32'((c % FT) == FT - 1));
    act = (c < 98) ? 32'h0 : (c < 196) ? 32'h1000 : 32'h2000;
    check("fb_active", fb_ptr_active, act);
    check("swap_pend", swap_pending,
          32'((c >= 21 && c <= 97) || (c >= 121 && c <= 195)));
    d = c - 3;
    if (d < 0) begin
      check("hs", vga_hs, 1);
      check("vs", vga_vs, 1);
      check("blank_n", vga_blank_n, 0);
      check("rgb", {vga_r, vga_g, vga_b}, 0);
    end else begin
      r = d % FT;
      hd = r % HT;
      vd = r / HT;
      bl = act_of(d);
      rgb = bl ? (addr_of(d) & 32'hFFFFFF) : 32'h0;
      check("hs", vga_hs, 32'(!(hd >= 10 && hd < 12)));
      check("vs", vga_vs, 32'(vd != 5));
      check("blank_n", vga_blank_n, 32'(bl));
      check("rgb", {vga_r, vga_g, vga_b}, rgb);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals();

    release_rst();
    for (int c = 0; c <= 205; c++) begin
      if (c > 0) tick();
      check_cycle(c);
      if (c == 20) begin
        fb_ptr_in = 32'h1000;
        fb_ptr_wr = 1'b1;
      end
      if (c == 120) begin
        fb_ptr_in = 32'h1800;
        fb_ptr_wr = 1'b1;
      end
      if (c == 195) begin
        fb_ptr_in = 32'h2000;
        fb_ptr_wr = 1'b1;
      end
    end

    // Reset in the middle of frame 2, cycle 50 of that frame.
    for (int c = 206; c <= 246; c++) tick();
    check("pre_rst_blank", vga_blank_n, 1);
    #1;
    reset_n = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(negedge clk);
    release_rst();
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) tick();
      check_cycle(c);
    end

`ifdef VGA_TEST_PATTERN_EN
    @(negedge clk);
    reset_n = 1'b0;
    test_mode = 1'b1;
    repeat (2) @(negedge clk);
    release_rst();
    for (int c = 0; c <= 16; c++) begin
      logic [2:0] b;
      int d;
      logic [31:0] rgb;
      if (c > 0) tick();
      check("tm_req", pix_req, 0);
      d = c - 3;
      if (d >= 0 && d < 8) begin
        b = 3'(d);
        rgb = {8'h0, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        check("tm_blank", vga_blank_n, 1);
        check("tm_rgb", {vga_r, vga_g, vga_b}, rgb);
      end else begin
        check("tm_rgb_off", {vga_r, vga_g, vga_b}, 0);
      end
    end
    test_mode = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
